mdu_iter: RTL

Parametrised iterative multiply/divide unit with HI/LO registers, added beside the ALU in the EX stage of the pipelined MIPS core. It supports MULT, MULTU, DIV, DIVU, MFHI/MFLO (read ports) and MTHI/MTLO (write ports). Each operation runs as a radix-2 shift-add multiply or restoring divide over WIDTH iterations. A start/busy/done handshake tells the hazard logic when to stall dependent HI/LO accesses.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_iter_if.sv | 27 ++
 rtl/mdu_iter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes, FSM states
// and the MIPS funct codes that the ALU decoder maps onto them.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, we_hi, we_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, we_hi, we_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers. Operands are reduced to
// magnitudes on start; signs are reapplied in the single FIX cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [WIDTH:0]   mul_sum, rem_ext, diff;
  logic [AccW-1:0]  mul_step, div_step, prod;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AccW-1:1]};

  // Divide: acc = {remainder, dividend bits / quotient bits}; rem_ext is the shifted remainder.
  assign rem_ext  = acc_q[AccW-1:WIDTH-1];
  assign diff     = rem_ext - {1'b0, opnd_q};
  assign div_step = diff[WIDTH] ? {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = acc_q[WIDTH-1:0];
  assign rem  = acc_q[AccW-1:WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.we_hi) hi_d = bus.wdata;
        if (bus.we_lo) lo_d = bus.wdata;
        if (bus.start && !bus.cancel) begin
          state_d = StCalc;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          opnd_d  = is_div ? b_mag : a_mag;
          cnt_d   = CntW'(WIDTH - 1);
          op_d    = bus.op;
          // A zero divisor must yield an all-ones quotient regardless of dividend sign.
          neg_d   = (a_neg ^ b_neg) & (!is_div || (bus.b != '0));
          rneg_d  = a_neg;
        end
      end
      StCalc: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = (op_q[1]) ? div_step : mul_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            lo_d = neg_q ? -quo : quo;
            hi_d = rneg_q ? -rem : rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
